spi_txn_arbiter: RTL and testbench

SPI_TXN_ARBITER -- requirements
Module: spi_txn_arbiter

---
 rtl/spi_txn_arbiter.sv | 183 ++++++++++++++++++
 tb/tb_spi_txn_arbiter.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_txn_arbiter.sv
// Round-robin arbiter that funnels requester SPI transactions into one engine.
// Ports: fabric_clk/reset_n; req_* requester side (valid/ready, length/data/mask
//   slices, per-requester enable); rsp_* shared response bus with one-hot valid;
//   eng_* engine launch/cs routing and completion; timeout_cycles; busy.
module spi_txn_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 32,
    parameter int LEN_WIDTH  = 8,
    parameter int TMO_WIDTH  = 16
) (
    input  logic                            fabric_clk,
    input  logic                            reset_n,
    input  logic [NUM_REQ-1:0]              req_enable,
    input  logic [TMO_WIDTH-1:0]            timeout_cycles,
    input  logic [NUM_REQ-1:0]              req_valid,
    output logic [NUM_REQ-1:0]              req_ready,
    input  logic [NUM_REQ*LEN_WIDTH-1:0]    req_length,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_data,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_mask,
    output logic [NUM_REQ-1:0]              rsp_valid,
    output logic [DATA_WIDTH-1:0]           rsp_data,
    output logic                            rsp_error,
    output logic                            rsp_timeout,
    output logic                            eng_start,
    output logic [LEN_WIDTH-1:0]            eng_length,
    output logic [DATA_WIDTH-1:0]           eng_data,
    output logic [DATA_WIDTH-1:0]           eng_mask,
    output logic [NUM_REQ-1:0]              eng_cs_sel,
    input  logic                            eng_done,
    input  logic [DATA_WIDTH-1:0]           eng_read_data,
    output logic                            busy
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, RESP} state_t;

    state_t                 state_q, state_d;
    logic [IW-1:0]          last_q, last_d;
    logic [IW-1:0]          gnt_q, gnt_d;
    logic [LEN_WIDTH-1:0]   len_q, len_d;
    logic [DATA_WIDTH-1:0]  data_q, data_d;
    logic [DATA_WIDTH-1:0]  mask_q, mask_d;
    logic [DATA_WIDTH-1:0]  rdata_q, rdata_d;
    logic [NUM_REQ-1:0]     cs_q, cs_d;
    logic                   err_q, err_d;
    logic                   tmo_q, tmo_d;
    logic [TMO_WIDTH-1:0]   timer_q, timer_d;

    logic [NUM_REQ-1:0]     elig;
    logic                   found;
    logic [IW-1:0]          pick;
    logic [IW-1:0]          idx;
    logic                   len_ok;
    logic [DATA_WIDTH-1:0]  len_mask;
    logic [NUM_REQ-1:0]     gnt_oh;

    assign elig = req_valid & req_enable;

    // First eligible requester after the previous winner, wrapping around.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        idx   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = IW'((32'(last_q) + 32'(k)) % 32'(NUM_REQ));
            if (!found && elig[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

    // Only bits below the transaction length carry read data.
    always_comb begin
        len_mask = '0;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            len_mask[i] = (32'(i) < 32'(len_q));
        end
    end

    assign len_ok = (len_q != '0) && (32'(len_q) <= 32'(DATA_WIDTH));
    assign gnt_oh = NUM_REQ'(1) << gnt_q;

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        gnt_d   = gnt_q;
        len_d   = len_q;
        data_d  = data_q;
        mask_d  = mask_q;
        rdata_d = rdata_q;
        cs_d    = cs_q;
        err_d   = err_q;
        tmo_d   = tmo_q;
        timer_d = timer_q;
        unique case (state_q)
            IDLE: begin
                if (found) begin
                    gnt_d   = pick;
                    len_d   = req_length[pick*LEN_WIDTH +: LEN_WIDTH];
                    data_d  = req_data[pick*DATA_WIDTH +: DATA_WIDTH];
                    mask_d  = req_mask[pick*DATA_WIDTH +: DATA_WIDTH];
                    cs_d    = NUM_REQ'(1) << pick;
                    err_d   = 1'b0;
                    tmo_d   = 1'b0;
                    rdata_d = '0;
                    state_d = LAUNCH;
                end
            end
            LAUNCH: begin
                timer_d = '0;
                if (!len_ok) begin
                    err_d   = 1'b1;
                    state_d = RESP;
                end else begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                // A completion in the final timeout cycle still counts.
                if (eng_done) begin
                    rdata_d = eng_read_data & ~mask_q & len_mask;
                    state_d = RESP;
                end else if (timeout_cycles != '0 &&
                             timer_q == timeout_cycles - TMO_WIDTH'(1)) begin
                    tmo_d   = 1'b1;
                    rdata_d = '0;
                    state_d = RESP;
                end else if (timer_q != '1) begin
                    timer_d = timer_q + TMO_WIDTH'(1);
                end
            end
            RESP: begin
                last_d  = gnt_q;
                cs_d    = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge fabric_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            last_q  <= IW'(NUM_REQ - 1);
            gnt_q   <= '0;
            len_q   <= '0;
            data_q  <= '0;
            mask_q  <= '0;
            rdata_q <= '0;
            cs_q    <= '0;
            err_q   <= 1'b0;
            tmo_q   <= 1'b0;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            gnt_q   <= gnt_d;
            len_q   <= len_d;
            data_q  <= data_d;
            mask_q  <= mask_d;
            rdata_q <= rdata_d;
            cs_q    <= cs_d;
            err_q   <= err_d;
            tmo_q   <= tmo_d;
            timer_q <= timer_d;
        end
    end

    assign req_ready   = (state_q == LAUNCH) ? gnt_oh : '0;
    assign eng_start   = (state_q == LAUNCH) && len_ok;
    assign rsp_valid   = (state_q == RESP) ? gnt_oh : '0;
    assign rsp_data    = (state_q == RESP) ? rdata_q : '0;
    assign rsp_error   = (state_q == RESP) && err_q;
    assign rsp_timeout = (state_q == RESP) && tmo_q;
    assign eng_length  = len_q;
    assign eng_data    = data_q;
    assign eng_mask    = mask_q;
    assign eng_cs_sel  = cs_q;
    assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_spi_txn_arbiter.sv
// Self-checking bench for spi_txn_arbiter: directed table, streams, random vs model.
// Drives all DUT ports directly; prints one summary line at the end.
module tb_spi_txn_arbiter;

    localparam int NR = 4;
    localparam int DW = 32;
    localparam int LW = 8;
    localparam int TW = 16;

    logic             clk = 1'b0;
    logic             reset_n;
    logic [NR-1:0]    req_enable;
    logic [TW-1:0]    timeout_cycles;
    logic [NR-1:0]    req_valid;
    logic [NR-1:0]    req_ready;
    logic [NR*LW-1:0] req_length;
    logic [NR*DW-1:0] req_data;
    logic [NR*DW-1:0] req_mask;
    logic [NR-1:0]    rsp_valid;
    logic [DW-1:0]    rsp_data;
    logic             rsp_error;
    logic             rsp_timeout;
    logic             eng_start;
    logic [LW-1:0]    eng_length;
    logic [DW-1:0]    eng_data;
    logic [DW-1:0]    eng_mask;
    logic [NR-1:0]    eng_cs_sel;
    logic             eng_done;
    logic [DW-1:0]    eng_read_data;
    logic             busy;

    int n_checks = 0;
    int n_fail   = 0;

    spi_txn_arbiter #(
        .NUM_REQ(NR), .DATA_WIDTH(DW), .LEN_WIDTH(LW), .TMO_WIDTH(TW)
    ) dut (
        .fabric_clk(clk), .reset_n(reset_n),
        .req_enable(req_enable), .timeout_cycles(timeout_cycles),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_length(req_length), .req_data(req_data), .req_mask(req_mask),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .rsp_error(rsp_error), .rsp_timeout(rsp_timeout),
        .eng_start(eng_start), .eng_length(eng_length),
        .eng_data(eng_data), .eng_mask(eng_mask), .eng_cs_sel(eng_cs_sel),
        .eng_done(eng_done), .eng_read_data(eng_read_data), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    always @(negedge clk) begin
        if (reset_n) begin
            n_checks++;
            if (!$onehot0(req_ready) || !$onehot0(rsp_valid) ||
                (rsp_error && rsp_timeout) || (!busy && eng_cs_sel != '0)) begin
                n_fail++;
                $display("FAIL monitor: rdy=%b rspv=%b err=%b to=%b busy=%b cs=%b",
                         req_ready, rsp_valid, rsp_error, rsp_timeout, busy, eng_cs_sel);
            end
        end
    end

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_payload(input int i, input int len, input logic [31:0] d,
                               input logic [31:0] m);
        req_length[i*LW +: LW] = LW'(len);
        req_data[i*DW +: DW]   = d;
        req_mask[i*DW +: DW]   = m;
    endtask

    // Spec rules: round-robin pick, then outcome from length/timeout/done timing.
    function automatic int rr_pick(input int last, input logic [3:0] el);
        for (int k = 1; k <= NR; k++) begin
            if (el[(last + k) % NR]) return (last + k) % NR;
        end
        return -1;
    endfunction

    task automatic predict(input int len, input logic [31:0] mask, input int tmo,
                           input int dly, input logic [31:0] rd,
                           output logic [31:0] d, output bit e, output bit t,
                           output int st, output int w);
        logic [63:0] full;
        if (len == 0 || len > DW) begin
            d = '0; e = 1'b1; t = 1'b0; st = 0; w = 0;
        end else if (tmo != 0 && (dly < 0 || dly > tmo)) begin
            d = '0; e = 1'b0; t = 1'b1; st = 1; w = tmo;
        end else begin
            full = (64'd1 << len) - 64'd1;
            d = 32'(64'(rd & ~mask) & full);
            e = 1'b0; t = 1'b0; st = 1; w = dly;
        end
    endtask

    // One transaction: assert requests, observe grant, run the engine, collect response.
    task automatic run_txn(input logic [3:0] vld, input logic [3:0] ena, input int tmo,
                           input int dly, input logic [31:0] rd, input bit glitch,
                           output int g, output logic [31:0] rdat, output bit err,
                           output bit to, output int starts, output int waits,
                           output bit got);
        int k;
        logic [LW-1:0] lcap;
        g = -1; rdat = '0; err = 0; to = 0; starts = 0; waits = -1; got = 0;
        timeout_cycles = TW'(tmo);
        req_enable = ena;
        req_valid = vld;
        eng_done = glitch;
        eng_read_data = rd;
        for (int n = 0; n < 20; n++) begin
            cyc();
            eng_done = 1'b0;
            if (req_ready != '0) break;
        end
        if (req_ready == '0) begin
            req_valid = '0;
            return;
        end
        for (int i = 0; i < NR; i++) if (req_ready[i]) g = i;
        lcap = req_length[g*LW +: LW];
        chk("launch_cs_sel", eng_cs_sel, req_ready);
        chk("launch_eng_len", eng_length, lcap);
        chk("launch_eng_data", eng_data, req_data[g*DW +: DW]);
        chk("launch_eng_mask", eng_mask, req_mask[g*DW +: DW]);
        starts = int'(eng_start);
        req_valid = '0;
        req_enable = '0;
        req_data = ~req_data;
        req_mask = ~req_mask;
        req_length = ~req_length;
        k = 0;
        for (int n = 0; n < 300; n++) begin
            eng_done = (k == dly);
            cyc();
            k++;
            eng_done = 1'b0;
            starts += int'(eng_start);
            if (rsp_valid != '0) begin
                got = 1; waits = k - 1;
                rdat = rsp_data; err = rsp_error; to = rsp_timeout;
                chk("rsp_port", rsp_valid, NR'(1) << g);
                chk("resp_len_hold", eng_length, lcap);
                chk("resp_cs_hold", eng_cs_sel, NR'(1) << g);
                break;
            end
        end
        cyc();
        chk("idle_after_resp", {busy, eng_cs_sel}, 5'b0);
    endtask

    int ord[8];
    int gcy[8];

    task automatic run_stream(input logic [3:0] vld, input logic [3:0] ena,
                              input int len, input int dly, input int ngr,
                              output int ng, output int starts, output int rsps);
        int done_at;
        for (int i = 0; i < NR; i++) set_payload(i, len, 32'hA5A5_0000 + i, '0);
        timeout_cycles = '0;
        req_valid = vld;
        req_enable = ena;
        ng = 0; starts = 0; rsps = 0; done_at = -1;
        for (int c = 0; c < 400; c++) begin
            eng_done = (c == done_at);
            cyc();
            eng_done = 1'b0;
            if (eng_start) begin
                starts++;
                done_at = c + 1 + dly;
            end
            if (rsp_valid != '0) rsps++;
            if (req_ready != '0 && ng < 8) begin
                for (int i = 0; i < NR; i++) if (req_ready[i]) ord[ng] = i;
                gcy[ng] = c;
                ng++;
                if (ng == ngr) req_valid = '0;
            end
            if (ng == ngr && !busy) break;
        end
    endtask

    typedef struct {
        int idx; int len; logic [31:0] data; logic [31:0] mask;
        int tmo; int dly; logic [31:0] rd;
        logic [31:0] exp_d; bit exp_e; bit exp_t; int exp_st; int exp_w;
    } vec_t;

    vec_t tbl[8];
    int m_len[NR];
    logic [31:0] m_data[NR];
    logic [31:0] m_mask[NR];
    int lastg_m;

    initial begin
        int g, st, w, ng, rs, p, tmo, dly;
        logic [31:0] rdat, ed, rd;
        bit err, to, got, ee, et, gl;
        int est, ew, quiet;
        logic [3:0] v, e;
        int exp_rr[6];
        int exp_alt[4];
        int exp_inv[4];

        tbl[0] = '{2, 16, 32'hAB00, 32'hFF00, 0, 10, 32'h12345, 32'h0045, 0, 0, 1, 10};
        tbl[1] = '{1, 0, 32'hFFFF, 32'h0, 0, -1, 32'hFFFF_FFFF, 32'h0, 1, 0, 0, 0};
        tbl[2] = '{3, 33, 32'h1234, 32'h0, 0, -1, 32'hFFFF_FFFF, 32'h0, 1, 0, 0, 0};
        tbl[3] = '{0, 8, 32'h5A, 32'h0, 8, -1, 32'hFFFF_FFFF, 32'h0, 0, 1, 1, 8};
        tbl[4] = '{0, 8, 32'h5A, 32'h0, 8, 8, 32'hFFFF_FFA5, 32'hA5, 0, 0, 1, 8};
        tbl[5] = '{1, 32, 32'h0, 32'h0F0F_0F0F, 0, 1, 32'hFFFF_FFFF, 32'hF0F0_F0F0, 0, 0, 1, 1};
        tbl[6] = '{2, 4, 32'hC, 32'h0, 1, -1, 32'hF, 32'h0, 0, 1, 1, 1};
        tbl[7] = '{3, 32, 32'h0, 32'h0, 3, 3, 32'h1234_5678, 32'h1234_5678, 0, 0, 1, 3};
        exp_rr  = '{0, 1, 2, 3, 0, 1};
        exp_alt = '{3, 1, 3, 1};
        exp_inv = '{2, 3, 0, 1};

        reset_n = 1'b0;
        req_enable = '0; timeout_cycles = '0; req_valid = '0;
        req_length = '0; req_data = '0; req_mask = '0;
        eng_done = 1'b0; eng_read_data = '0;
        cyc();
        cyc();
        chk("reset_outputs", {req_ready, rsp_valid, rsp_data, rsp_error, rsp_timeout,
            eng_start, eng_length, eng_data, eng_mask, eng_cs_sel, busy}, '0);
        reset_n = 1'b1;
        cyc();

        run_stream(4'hF, 4'hF, 8, 3, 6, ng, st, rs);
        chk("rr_count", ng, 6);
        for (int i = 0; i < 6; i++) chk($sformatf("rr_order_%0d", i), ord[i], exp_rr[i]);
        chk("rr_starts", st, 6);
        chk("rr_rsps", rs, 6);

        run_stream(4'hF, 4'b1010, 8, 2, 4, ng, st, rs);
        chk("en1010_count", ng, 4);
        for (int i = 0; i < 4; i++) chk($sformatf("en1010_order_%0d", i), ord[i], exp_alt[i]);

        run_stream(4'hF, 4'hF, 0, 2, 4, ng, st, rs);
        chk("inv_count", ng, 4);
        for (int i = 0; i < 4; i++) chk($sformatf("inv_order_%0d", i), ord[i], exp_inv[i]);
        for (int i = 1; i < 4; i++) chk($sformatf("inv_period_%0d", i), gcy[i] - gcy[i-1], 3);
        chk("inv_no_start", st, 0);
        chk("inv_rsps", rs, 4);

        for (int t = 0; t < 8; t++) begin
            set_payload(tbl[t].idx, tbl[t].len, tbl[t].data, tbl[t].mask);
            run_txn(4'(1 << tbl[t].idx), 4'hF, tbl[t].tmo, tbl[t].dly, tbl[t].rd, 1'b0,
                    g, rdat, err, to, st, w, got);
            chk($sformatf("tbl%0d_grant", t), g, tbl[t].idx);
            chk($sformatf("tbl%0d_got", t), got, 1);
            chk($sformatf("tbl%0d_data", t), rdat, tbl[t].exp_d);
            chk($sformatf("tbl%0d_err", t), err, tbl[t].exp_e);
            chk($sformatf("tbl%0d_tmo", t), to, tbl[t].exp_t);
            chk($sformatf("tbl%0d_starts", t), st, tbl[t].exp_st);
            chk($sformatf("tbl%0d_waits", t), w, tbl[t].exp_w);
        end
        lastg_m = tbl[7].idx;

        for (int it = 0; it < 60; it++) begin
            do begin
                v = 4'($urandom);
                e = 4'($urandom);
            end while ((v & e) == 4'h0);
            for (int i = 0; i < NR; i++) begin
                case ($urandom_range(0, 9))
                    0: m_len[i] = 0;
                    1: m_len[i] = 33 + int'($urandom_range(0, 222));
                    2: m_len[i] = 32;
                    default: m_len[i] = int'($urandom_range(1, 32));
                endcase
                m_data[i] = $urandom;
                m_mask[i] = $urandom;
                set_payload(i, m_len[i], m_data[i], m_mask[i]);
            end
            tmo = int'($urandom_range(0, 6));
            dly = int'($urandom_range(1, 8));
            rd = $urandom;
            gl = 1'($urandom);
            p = rr_pick(lastg_m, v & e);
            run_txn(v, e, tmo, dly, rd, gl, g, rdat, err, to, st, w, got);
            predict(m_len[p], m_mask[p], tmo, dly, rd, ed, ee, et, est, ew);
            chk("rnd_grant", g, p);
            chk("rnd_got", got, 1);
            chk("rnd_data", rdat, ed);
            chk("rnd_err", err, ee);
            chk("rnd_tmo", to, et);
            chk("rnd_starts", st, est);
            chk("rnd_waits", w, ew);
            lastg_m = p;
        end

        set_payload(2, 8, 32'hFF, 32'h0);
        timeout_cycles = '0;
        req_enable = 4'hF;
        req_valid = 4'b0100;
        for (int n = 0; n < 20; n++) begin
            cyc();
            if (req_ready != '0) break;
        end
        chk("rst_mid_grant", req_ready, 4'b0100);
        req_valid = '0;
        cyc();
        cyc();
        chk("rst_mid_busy", busy, 1'b1);
        reset_n = 1'b0;
        #1;
        chk("rst_mid_outputs", {req_ready, rsp_valid, rsp_data, rsp_error, rsp_timeout,
            eng_start, eng_length, eng_data, eng_mask, eng_cs_sel, busy}, '0);
        cyc();
        reset_n = 1'b1;
        eng_done = 1'b1;
        eng_read_data = 32'hFFFF_FFFF;
        cyc();
        eng_done = 1'b0;
        quiet = 1;
        for (int n = 0; n < 4; n++) begin
            if (rsp_valid != '0 || busy) quiet = 0;
            cyc();
        end
        chk("rst_no_rsp", quiet, 1);
        set_payload(1, 8, 32'h3C, 32'h0);
        run_txn(4'b1110, 4'hF, 0, 2, 32'h0000_00C3, 1'b0, g, rdat, err, to, st, w, got);
        chk("rst_next_grant", g, 1);
        chk("rst_next_data", rdat, 32'hC3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
